vedic_pp_combiner: RTL and testbench
====================================

Name: vedic_pp_combiner

Overview:
- Pipelined back-end of the 16-bit fixed-point Vedic multiplier.
- Consumes the four 16-bit unsigned partial products from the 8x8 Vedic cores on the operand magnitudes, plus the result sign.
- Sums them into a 32-bit magnitude, applies sign, rounding and saturation, and emits a signed Q(16-FRAC).FRAC result.
- Uses a valid/ready handshake on both sides; the stage-1 mid-term sum follows the same add structure as the multiplier's ripple adders.

Parameters:
- FRAC, 8: fractional bits of the input and output format (legal range 1..15).
- PP_W, 16: partial-product width; fixed by the 8x8 cores and not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  partial-product set valid.
- in_ready  out  1  stage can accept this cycle.
- pp_ll  in  16  aL*bL.
- pp_lh  in  16  aL*bH.
- pp_hl  in  16  aH*bL.
- pp_hh  in  16  aH*bH.
- sign  in  1  sign_a XOR sign_b (1 = negative result).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- result  out  16  signed fixed-point product.
- ovf  out  1  saturation occurred for this result.

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage valids, out_valid, result and ovf go to 0; in-flight data is discarded. Reset mid-operation drops all three stages. in_ready=1 in the first cycle after reset.
- Pipeline (3 stages, global stall):
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When ~stall, every stage advances: a bubble enters when in_valid=0.
  - When stall, all stage registers hold.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - Latency: 3 cycles from input transfer to out_valid with no stall. Throughput: 1 per cycle.
- Stage 1:
  - mid = pp_lh + pp_hl, 17 bits (carry kept).
  - Register pp_ll, pp_hh, sign and mid.
- Stage 2:
  - P = {pp_hh, pp_ll} + (mid << 8), 32 bits.
  - Cannot exceed 0xFFFF_FFFF for 8x8 products, so no carry-out is needed.
- Stage 3 (round and saturate):
  - R = (P + 2^(FRAC-1)) >> FRAC, width 33-FRAC. Rounding is half-up on the magnitude, i.e. symmetric about zero.
  - sign=0: if R > 32767, result=0x7FFF and ovf=1; else result=R and ovf=0.
  - sign=1: if R > 32768, result=0x8000 and ovf=1; else result=-R (two's complement) and ovf=0. R=32768 yields exactly 0x8000 with ovf=0.
  - R=0 always yields 0x0000, including sign=1 (no negative zero).
- Output hold: result, ovf and out_valid hold unchanged while stalled. Data changes only on a non-stalled edge.
- Simultaneous events: out_ready=1 while in_valid=1 with a full pipe gives a simultaneous in/out transfer with no bubble.
- Handshake rules:
  - in_valid may drop without a transfer.
  - Inputs are sampled only on an input transfer.
  - X on pp_* while in_valid=0 must not reach result.

Decomposition:
- Shared package vedic_pkg:
  - PP_W=16, PROD_W=32, RES_W=16.
  - SAT_POS=16'h7FFF, SAT_NEG=16'h8000.
  - function round_const(FRAC).
- One natural sub-module: vedic_round_sat, purely combinational stage-3 logic. Inputs P[31:0], sign; outputs result[15:0], ovf; parameter FRAC. It is reused by future MAC variants.
- Stages 1-2 stay inline.

Test Plan:
- Basic product, Q8.8 1.5*2.0: pp_ll=0x0000, pp_lh=0x0100, pp_hl=0x0000, pp_hh=0x0002, sign=0, out_ready=1 -> P=0x0003_0000; result=0x0300, ovf=0, out_valid exactly 3 cycles after the transfer. Same with sign=1 -> result=0xFD00.
- Rounding:
  - pp_ll=0x0080, others 0, sign=0 -> 0x0001.
  - Same with sign=1 -> 0xFFFF.
  - pp_ll=0x007F, sign=1 -> 0x0000 (no negative zero).
- Saturation:
  - pp_hh=0xFFFF, others 0, sign=0 -> 0x7FFF with ovf=1.
  - Same with sign=1 -> 0x8000 with ovf=1.
  - pp_hh=0x0080, sign=1 -> 0x8000 with ovf=0.
  - pp_hh=0x0080, sign=0 -> 0x7FFF with ovf=1.
- Back-pressure: stream 5 products back-to-back, hold out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 during the stall, result stable, all 5 results delivered in order with none lost or duplicated. Also cover a random valid/ready soak checked against a reference model.
- Reset mid-flight: 2 products in flight, assert rst_n=0 for 1 cycle -> out_valid=0, result=0, ovf=0 next cycle; no stale result ever appears afterwards.
- Parameter sweep: FRAC=4 and FRAC=12 with a random 10k-vector soak -> bit-exact against the reference model for rounding and saturation.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the Vedic multiplier back-end.
//   PP_W   : width of one 8x8 partial product
//   PROD_W : width of the full unsigned magnitude product
//   RES_W  : width of the signed fixed-point result
//   SAT_POS/SAT_NEG : clamp values for the signed result
//   round_const(frac) : half-LSB constant added before the >> frac
package vedic_pkg;
  localparam int PP_W   = 16;
  localparam int PROD_W = 32;
  localparam int RES_W  = 16;

  localparam logic [RES_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [RES_W-1:0] SAT_NEG = 16'h8000;

  function automatic logic [PROD_W-1:0] round_const(input int frac);
    return PROD_W'(1) << (frac - 1);
  endfunction
endpackage

// File: rtl/vedic_round_sat.sv
// Round-half-up on the magnitude, then apply sign and saturate to a signed
// RES_W-bit result. Purely combinational.
//   p      : unsigned 32-bit product magnitude
//   sign   : 1 = negative result
//   result : signed Q(16-FRAC).FRAC result
//   ovf    : result was clamped
module vedic_round_sat
  import vedic_pkg::*;
#(
  parameter int FRAC = 8
) (
  input  logic [PROD_W-1:0] p,
  input  logic              sign,
  output logic [RES_W-1:0]  result,
  output logic              ovf
);
  // One extra bit so p + half-LSB cannot wrap at p = 0xFFFF_FFFF.
  logic [PROD_W:0] sum;
  logic [PROD_W:0] mag;

  always_comb begin
    sum    = {1'b0, p} + {1'b0, round_const(FRAC)};
    mag    = sum >> FRAC;
    result = '0;
    ovf    = 1'b0;
    if (!sign) begin
      if (mag > (PROD_W+1)'(SAT_POS)) begin
        result = SAT_POS;
        ovf    = 1'b1;
      end else begin
        result = mag[RES_W-1:0];
      end
    end else begin
      // Magnitude 32768 negates exactly to 0x8000; zero stays zero.
      if (mag > (PROD_W+1)'(SAT_NEG)) begin
        result = SAT_NEG;
        ovf    = 1'b1;
      end else begin
        result = RES_W'(0) - mag[RES_W-1:0];
      end
    end
  end
endmodule

// File: rtl/vedic_pp_combiner.sv
// Pipelined back-end of the 16-bit fixed-point Vedic multiplier.
// Stage 1 adds the two cross terms, stage 2 forms the 32-bit magnitude,
// stage 3 rounds, signs and saturates into result/ovf.
// One global stall freezes every stage when the output is held.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : partial-product handshake
//   pp_ll/lh/hl/hh, sign : 8x8 partial products and result sign
//   out_valid / out_ready: result handshake
//   result, ovf          : signed product and saturation flag
module vedic_pp_combiner #(
  parameter int FRAC = 8,
  parameter int PP_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PP_W-1:0] pp_ll,
  input  logic [PP_W-1:0] pp_lh,
  input  logic [PP_W-1:0] pp_hl,
  input  logic [PP_W-1:0] pp_hh,
  input  logic            sign,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     result,
  output logic            ovf
);
  import vedic_pkg::*;

  localparam int STAGES = 3;

  logic              stall;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;

  logic [PP_W-1:0]   s1_ll_q, s1_ll_d, s1_hh_q, s1_hh_d;
  logic [PP_W:0]     s1_mid_q, s1_mid_d;
  logic              s1_sign_q, s1_sign_d;
  logic [PROD_W-1:0] s2_p_q, s2_p_d;
  logic              s2_sign_q, s2_sign_d;
  logic [RES_W-1:0]  result_q, result_d, rs_result;
  logic              ovf_q, ovf_d, rs_ovf;

  assign vld_pipe  = {vld_pipe_q, in_valid};
  assign stall     = vld_pipe_q[STAGES] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe_q[STAGES];
  assign result    = result_q;
  assign ovf       = ovf_q;

  vedic_round_sat #(.FRAC(FRAC)) u_round_sat (
    .p      (s2_p_q),
    .sign   (s2_sign_q),
    .result (rs_result),
    .ovf    (rs_ovf)
  );

  // Data registers load only behind a valid, so bubbles (and any X on the
  // pp inputs while in_valid=0) never propagate into result.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_ll_d    = s1_ll_q;
    s1_hh_d    = s1_hh_q;
    s1_mid_d   = s1_mid_q;
    s1_sign_d  = s1_sign_q;
    s2_p_d     = s2_p_q;
    s2_sign_d  = s2_sign_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    if (!stall) begin
      vld_pipe_d = vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) begin
        s1_ll_d   = pp_ll;
        s1_hh_d   = pp_hh;
        s1_mid_d  = {1'b0, pp_lh} + {1'b0, pp_hl};
        s1_sign_d = sign;
      end
      if (vld_pipe[1]) begin
        // Real 8x8 products keep this sum within 32 bits.
        s2_p_d    = {s1_hh_q, s1_ll_q} + (PROD_W'(s1_mid_q) << (PP_W/2));
        s2_sign_d = s1_sign_q;
      end
      if (vld_pipe[2]) begin
        result_d = rs_result;
        ovf_d    = rs_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_ll_q    <= '0;
      s1_hh_q    <= '0;
      s1_mid_q   <= '0;
      s1_sign_q  <= 1'b0;
      s2_p_q     <= '0;
      s2_sign_q  <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_ll_q    <= s1_ll_d;
      s1_hh_q    <= s1_hh_d;
      s1_mid_q   <= s1_mid_d;
      s1_sign_q  <= s1_sign_d;
      s2_p_q     <= s2_p_d;
      s2_sign_q  <= s2_sign_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_vedic_pp_combiner.sv
module tb_vedic_pp_combiner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] pp_ll = '0, pp_lh = '0, pp_hl = '0, pp_hh = '0;
  logic        sign = 1'b0;

  logic [2:0]  ir, ov, of;
  logic [15:0] res [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer arithmetic, round half-up on magnitude, clamp signed.
  function automatic logic [16:0] model(input logic [15:0] ll, lh, hl, hh,
                                        input logic s, input int frac);
    longint p, half, r, v;
    logic   o;
    p    = longint'(hh) * 65536 + longint'(ll) + (longint'(lh) + longint'(hl)) * 256;
    half = longint'(1) << (frac - 1);
    r    = (p + half) / (half * 2);
    v    = s ? -r : r;
    o    = 1'b0;
    if (v > 32767)  begin v = 32767;  o = 1'b1; end
    if (v < -32768) begin v = -32768; o = 1'b1; end
    return {o, v[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int FR = (g == 0) ? 8 : ((g == 1) ? 4 : 12);
    logic [16:0] sbq [$];
    int n_in  = 0;
    int n_out = 0;

    vedic_pp_combiner #(.FRAC(FR)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[g]),
      .pp_ll(pp_ll), .pp_lh(pp_lh), .pp_hl(pp_hl), .pp_hh(pp_hh), .sign(sign),
      .out_valid(ov[g]), .out_ready(out_ready), .result(res[g]), .ovf(of[g])
    );

    // Scoreboard: decide transfers mid-cycle, ahead of the edge that takes them.
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        n_in  = 0;
        n_out = 0;
      end else begin
        if (ov[g] && out_ready) begin
          if (sbq.size() == 0) chk($sformatf("f%0d_spurious_out", FR), 32'd1, 32'd0);
          else begin
            chk($sformatf("f%0d_sb#%0d", FR, n_out), {15'd0, of[g], res[g]}, {15'd0, sbq.pop_front()});
            n_out++;
          end
        end
        if (in_valid && ir[g]) begin
          sbq.push_back(model(pp_ll, pp_lh, pp_hl, pp_hh, sign, FR));
          n_in++;
        end
      end
    end
  end

  typedef struct packed {
    logic [15:0] ll, lh, hl, hh;
    logic        s;
    logic [15:0] er;
    logic        eo;
  } vec_t;

  vec_t vt [9];

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    pp_ll = v.ll; pp_lh = v.lh; pp_hl = v.hl; pp_hh = v.hh; sign = v.s;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    pp_ll = 'x; pp_lh = 'x; pp_hl = 'x; pp_hh = 'x; sign = 'x;
  endtask

  initial begin
    logic [15:0] held;
    int idx, hold_left, base, guard;
    logic seen;
    logic [7:0] al, ah, bl, bh;

    vt[0] = '{16'h0000, 16'h0100, 16'h0000, 16'h0002, 1'b0, 16'h0300, 1'b0};
    vt[1] = '{16'h0000, 16'h0100, 16'h0000, 16'h0002, 1'b1, 16'hFD00, 1'b0};
    vt[2] = '{16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0};
    vt[3] = '{16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0};
    vt[4] = '{16'h007F, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vt[5] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1};
    vt[6] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 16'h8000, 1'b1};
    vt[7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0080, 1'b1, 16'h8000, 1'b0};
    vt[8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0080, 1'b0, 16'h7FFF, 1'b1};

    // Reset state
    idle();
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("rst_result", {16'd0, res[0]}, 32'd0);
    chk("rst_ovf", {31'd0, of[0]}, 32'd0);
    chk("rst_in_ready", {31'd0, ir[0]}, 32'd1);

    // Directed vectors, one at a time, latency checked on each
    for (int i = 0; i < 9; i++) begin
      drive(vt[i]);
      step();
      idle();
      chk($sformatf("dir%0d_lat1", i), {31'd0, ov[0]}, 32'd0);
      step();
      chk($sformatf("dir%0d_lat2", i), {31'd0, ov[0]}, 32'd0);
      step();
      chk($sformatf("dir%0d_valid", i), {31'd0, ov[0]}, 32'd1);
      chk($sformatf("dir%0d_result", i), {16'd0, res[0]}, {16'd0, vt[i].er});
      chk($sformatf("dir%0d_ovf", i), {31'd0, of[0]}, {31'd0, vt[i].eo});
      step();
    end

    // Back-pressure: 5 back-to-back, out_ready low 4 cycles after first out_valid
    base = gi[0].n_out;
    idx = 0; hold_left = 0; seen = 1'b0; held = '0;
    for (int c = 0; c < 40 && gi[0].n_out < base + 5; c++) begin
      if (ov[0] && !seen) begin
        seen = 1'b1;
        hold_left = 4;
        held = res[0];
      end
      out_ready = (hold_left == 0);
      if (idx < 5) drive(vt[idx]); else idle();
      @(negedge clk);
      if (hold_left > 0) begin
        chk($sformatf("bp_in_ready_c%0d", c), {31'd0, ir[0]}, 32'd0);
        chk($sformatf("bp_hold_valid_c%0d", c), {31'd0, ov[0]}, 32'd1);
        chk($sformatf("bp_hold_result_c%0d", c), {16'd0, res[0]}, {16'd0, held});
        hold_left--;
      end
      if (in_valid && ir[0]) idx++;
      step();
    end
    idle();
    out_ready = 1'b1;
    chk("bp_delivered", gi[0].n_out - base, 32'd5);
    step();
    step();
    chk("bp_no_extra", gi[0].n_out - base, 32'd5);

    // Reset mid-flight with a non-zero result on the output
    drive(vt[0]); step();
    drive(vt[5]); step();
    idle(); step();
    chk("mid_pre_valid", {31'd0, ov[0]}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'd0, ov[0]}, 32'd0);
    chk("mid_rst_result", {16'd0, res[0]}, 32'd0);
    chk("mid_rst_ovf", {31'd0, of[0]}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, ir[0]}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("mid_no_stale_c%0d", c), {29'd0, ov}, 32'd0);
    end

    // Random valid/ready soak across FRAC = 8, 4, 12
    guard = 0;
    while (gi[0].n_in < 10000 && guard < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      al = 8'($urandom); ah = 8'($urandom); bl = 8'($urandom); bh = 8'($urandom);
      pp_ll = al * bl; pp_lh = al * bh; pp_hl = ah * bl; pp_hh = ah * bh;
      sign  = 1'($urandom);
      step();
      guard++;
    end
    chk("soak_budget", {31'd0, guard < 60000}, 32'd1);
    idle();
    out_ready = 1'b1;
    repeat (6) step();
    chk("soak_drain_f8",  gi[0].n_out, gi[0].n_in);
    chk("soak_drain_f4",  gi[1].n_out, gi[1].n_in);
    chk("soak_drain_f12", gi[2].n_out, gi[2].n_in);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
